// File: rtl/cla_pkg.sv
// Shared types and constants for the CLA adder self-test block.
package cla_pkg;

   localparam int         CLA_W   = 5;
   localparam int         VW      = 2*CLA_W+1;
   localparam logic [7:0] ERR_MAX = 8'hFF;

   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_e;

   // Reference result, kept one bit wider than the operands so the carry survives.
   function automatic logic [CLA_W:0] exp_sum(input logic [CLA_W-1:0] a,
                                               input logic [CLA_W-1:0] b,
                                               input logic             cin);
      return {1'b0, a} + {1'b0, b} + {{CLA_W{1'b0}}, cin};
   endfunction

endpackage

// File: rtl/cla_if.sv
// Operand/result bus between the self-test driver (master) and the adder (slave).
interface cla_if import cla_pkg::*; #(parameter int WIDTH = CLA_W);

   logic [WIDTH-1:0] a_o;
   logic [WIDTH-1:0] b_o;
   logic             cin_o;
   logic [WIDTH-1:0] sum_i;
   logic             cout_i;

   modport master (output a_o, b_o, cin_o, input  sum_i, cout_i);
   modport slave  (input  a_o, b_o, cin_o, output sum_i, cout_i);

endinterface

// File: rtl/cla_vec_gen.sv
// Test vector counter: {cin,b,a} packed, with clear, increment and all-ones flag.
module cla_vec_gen import cla_pkg::*; #(
   parameter int W = VW
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] vec,
   output logic         last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   vec <= '0;
      else if (clr) vec <= '0;
      else if (inc) vec <= vec + 1'b1;
   end

   assign last = &vec;

endmodule

// File: rtl/cla_self_test.sv
// Exhaustive sweep driver and checker for a WIDTH-bit adder; reports pass/fail,
// saturating error count and the first failing {cin,b,a} vector.
module cla_self_test import cla_pkg::*; #(
   parameter int WIDTH         = CLA_W,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   cla_if.master            add,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [7:0]       err_count,
   output logic [2*WIDTH:0] first_fail,
   output logic             first_fail_vld
);

   localparam int VECW = 2*WIDTH+1;

   state_e          state;
   logic [3:0]      settle_cnt;
   logic [VECW-1:0] vec;
   logic            vec_last;
   logic            go;
   logic            vec_inc;
   logic [WIDTH:0]  exp_res;
   logic            mismatch;
   logic [7:0]      err_nxt;

   // start only has effect when no sweep is running
   assign go      = start && (state == IDLE || state == DONE);
   assign vec_inc = (state == CHECK) && !vec_last;

   cla_vec_gen #(.W(VECW)) u_vec (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (go),
      .inc   (vec_inc),
      .vec   (vec),
      .last  (vec_last)
   );

   assign exp_res  = {1'b0, add.a_o} + {1'b0, add.b_o} + {{WIDTH{1'b0}}, add.cin_o};
   assign mismatch = (state == CHECK) && ({add.cout_i, add.sum_i} != exp_res);
   assign err_nxt  = (mismatch && err_count != ERR_MAX) ? err_count + 8'd1 : err_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         settle_cnt     <= '0;
         add.a_o        <= '0;
         add.b_o        <= '0;
         add.cin_o      <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail           <= 1'b0;
         err_count      <= '0;
         first_fail     <= '0;
         first_fail_vld <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= APPLY;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  fail           <= 1'b0;
                  err_count      <= '0;
                  first_fail     <= '0;
                  first_fail_vld <= 1'b0;
               end
            end
            APPLY: begin
               add.a_o    <= vec[WIDTH-1:0];
               add.b_o    <= vec[2*WIDTH-1:WIDTH];
               add.cin_o  <= vec[2*WIDTH];
               settle_cnt <= 4'(SETTLE_CYCLES-1);
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == 4'd0) state <= CHECK;
               else                    settle_cnt <= settle_cnt - 4'd1;
            end
            CHECK: begin
               err_count <= err_nxt;
               if (mismatch && !first_fail_vld) begin
                  first_fail     <= vec;
                  first_fail_vld <= 1'b1;
               end
               // verdict uses err_nxt so the last vector's result is included
               if (vec_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_nxt == 8'd0);
                  fail  <= (err_nxt != 8'd0);
               end else begin
                  state <= APPLY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_self_test.sv
// Scoreboard bench for cla_self_test driving a behavioural adder with injectable faults.
module tb_cla_self_test;
   import cla_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, pass, fail, first_fail_vld;
   logic [7:0]  err_count;
   logic [10:0] first_fail;
   int          fault = 0;
   int          total = 0;
   int          bad = 0;

   cla_if #(.WIDTH(5)) add ();

   always #5 clk = ~clk;

   // behavioural adder: fault 1 = sum[0] stuck at 0, fault 2 = cout stuck at 0
   logic [5:0] raw;
   assign raw        = {1'b0, add.a_o} + {1'b0, add.b_o} + {5'b0, add.cin_o};
   assign add.sum_i  = (fault == 1) ? {raw[4:1], 1'b0} : raw[4:0];
   assign add.cout_i = (fault == 2) ? 1'b0 : raw[5];

   cla_self_test #(.WIDTH(5), .SETTLE_CYCLES(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .add            (add),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail           (fail),
      .err_count      (err_count),
      .first_fail     (first_fail),
      .first_fail_vld (first_fail_vld)
   );

   typedef struct {
      logic        pass;
      logic        fail;
      logic [7:0]  err;
      logic [10:0] ff;
      logic        ffv;
      int          lat;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {29'd0, busy, done, pass, fail, err_count, first_fail, first_fail_vld,
              add.a_o, add.b_o, add.cin_o};
   endfunction

   // monitor: on each rising done, pop the expected verdict and compare
   initial begin
      exp_t e;
      int   run = 0;
      logic busy_d = 1'b0;
      logic done_d = 1'b0;
      forever begin
         @(negedge clk);
         if (busy && !busy_d) run = 1;
         else if (busy)       run++;
         if (done && !done_d) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = q.pop_front();
               chk("pass",           pass,           e.pass);
               chk("fail",           fail,           e.fail);
               chk("err_count",      err_count,      e.err);
               chk("first_fail",     first_fail,     e.ff);
               chk("first_fail_vld", first_fail_vld, e.ffv);
               chk("busy_cycles",    run,            e.lat);
            end
         end
         busy_d = busy;
         done_d = done;
      end
   end

   task automatic push(input logic p, input logic [7:0] err, input logic [10:0] ff, input logic ffv);
      exp_t e;
      e.pass = p; e.fail = !p; e.err = err; e.ff = ff; e.ffv = ffv; e.lat = 8192;
      q.push_back(e);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int n = 0;
      while (!done && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   initial begin
      // reset asserted mid-cycle clears everything at once
      #1 rst_n = 1'b0;
      #1 chk("reset_outputs", all_outs(), 64'd0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); chk("reset_beats_start", busy, 1'b0);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_outputs", all_outs(), 64'd0);

      // golden sweep with stray start pulses while busy
      push(1'b1, 8'd0, 11'h000, 1'b0);
      pulse_start();
      chk("busy_after_start", busy, 1'b1);
      repeat (100) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (3900) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_done(9000);
      repeat (3) @(negedge clk);
      chk("hold_a",    add.a_o,   5'd31);
      chk("hold_b",    add.b_o,   5'd31);
      chk("hold_cin",  add.cin_o, 1'b1);
      chk("done_busy", {done, busy}, 2'b10);

      // re-run from DONE clears the verdict on the sampling edge
      push(1'b1, 8'd0, 11'h000, 1'b0);
      pulse_start();
      chk("rerun_clear", {busy, done, pass, fail, err_count}, {4'b1000, 8'd0});
      wait_done(9000);

      // sum[0] stuck at 0: odd totals fail, first at a=1
      fault = 1;
      push(1'b0, 8'hFF, 11'h001, 1'b1);
      pulse_start();
      wait_done(9000);

      // cout stuck at 0: first overflow is a=31,b=1,cin=0
      fault = 2;
      push(1'b0, 8'hFF, 11'h03F, 1'b1);
      pulse_start();
      chk("fault_rerun_clear", {err_count, first_fail_vld, fail}, 10'd0);
      wait_done(9000);

      // reset partway through a sweep drops all partial results
      fault = 0;
      pulse_start();
      repeat (2998) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("midsweep_reset", all_outs(), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("after_reset_idle", {busy, done}, 2'b00);

      push(1'b1, 8'd0, 11'h000, 1'b0);
      pulse_start();
      wait_done(9000);
      repeat (2) @(negedge clk);

      chk("scoreboard_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
